// File: rtl/axil_reg_pkg.sv
`default_nettype none
// ============================================================================
// Package : axil_reg_pkg
// Desc    : Shared response codes, read FSM states and width helpers for the
//           AXI-Lite register read front end.
// Rev     : 1.0  initial release
// ============================================================================
package axil_reg_pkg;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_REQ  = 1'b1
    } rd_state_e;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Timer only has to hold TIMEOUT-1.
    function automatic int timer_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axil_reg_rd_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module : axil_reg_rd_resp_fifo
// Desc   : First-word-fall-through response FIFO with occupancy output.
// Rev    : 1.0  initial release
// ============================================================================
module axil_reg_rd_resp_fifo
    import axil_reg_pkg::*;
#(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_i,
    input  logic [WIDTH-1:0]              push_data_i,
    input  logic                          pop_i,
    output logic [WIDTH-1:0]              pop_data_o,
    output logic                          valid_o,
    output logic [level_width(DEPTH)-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty_w;
    logic             full_w;
    logic             push_ok_w;
    logic             pop_ok_w;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_w   = (wr_ptr_q == rd_ptr_q);
    assign full_w    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok_w = push_i && !full_w;
    assign pop_ok_w  = pop_i && !empty_w;

    assign wr_ptr_d  = push_ok_w ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d  = pop_ok_w  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_w) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];
    assign valid_o    = !empty_w;
    assign level_o    = wr_ptr_q - rd_ptr_q;

endmodule
`default_nettype wire

// File: rtl/axil_reg_if_rd_buf.sv
`default_nettype none
// ============================================================================
// Module : axil_reg_if_rd_buf
// Desc   : AXI-Lite read front end issuing single register reads, with ack
//          timeout and a buffered response FIFO. Define
//          AXIL_REG_RD_TIMEOUT_SLVERR_EN to answer timeouts with SLVERR/0.
// Rev    : 1.0  initial release
// ============================================================================
module axil_reg_if_rd_buf
    import axil_reg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 4,
    parameter int RESP_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ADDR_WIDTH-1:0]              s_axil_araddr,
    input  logic [2:0]                         s_axil_arprot,
    input  logic                               s_axil_arvalid,
    output logic                               s_axil_arready,
    output logic [DATA_WIDTH-1:0]              s_axil_rdata,
    output logic [1:0]                         s_axil_rresp,
    output logic                               s_axil_rvalid,
    input  logic                               s_axil_rready,
    output logic [ADDR_WIDTH-1:0]              reg_rd_addr,
    output logic                               reg_rd_en,
    input  logic [DATA_WIDTH-1:0]              reg_rd_data,
    input  logic                               reg_rd_wait,
    input  logic                               reg_rd_ack,
    output logic                               stat_timeout,
    output logic [level_width(RESP_DEPTH)-1:0] resp_level
);

    localparam int                LVL_W    = level_width(RESP_DEPTH);
    localparam int                TMR_W    = timer_width(TIMEOUT);
    localparam logic [LVL_W-1:0]  DEPTH_L  = LVL_W'(RESP_DEPTH);
    localparam logic [TMR_W-1:0]  TMR_LOAD = (TIMEOUT == 0) ? '0 : TMR_W'(TIMEOUT - 1);

    rd_state_e                   state_q, state_d;
    logic [TMR_W-1:0]            tmr_q, tmr_d;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic                        stat_q;
    logic                        ar_fire_w;
    logic                        ack_w;
    logic                        timeout_w;
    logic                        push_w;
    logic [DATA_WIDTH+1:0]       push_data_w;
    logic [DATA_WIDTH+1:0]       pop_data_w;
    logic                        unused_arprot_w;

    assign unused_arprot_w = ^s_axil_arprot;

    // Busy is implied by RD_REQ, so (level + busy) < depth reduces to level < depth.
    assign s_axil_arready = !rst && (state_q == RD_IDLE) && (resp_level < DEPTH_L);
    assign ar_fire_w      = s_axil_arvalid && s_axil_arready;

    assign ack_w     = (state_q == RD_REQ) && reg_rd_ack;
    assign timeout_w = (TIMEOUT != 0) && (state_q == RD_REQ) && (tmr_q == '0) && !reg_rd_ack;
    assign push_w    = ack_w || timeout_w;

`ifdef AXIL_REG_RD_TIMEOUT_SLVERR_EN
    assign push_data_w = timeout_w ? {{DATA_WIDTH{1'b0}}, AXIL_RESP_SLVERR}
                                   : {reg_rd_data, AXIL_RESP_OKAY};
`else
    assign push_data_w = {reg_rd_data, AXIL_RESP_OKAY};
`endif

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        addr_d  = addr_q;
        case (state_q)
            RD_IDLE: begin
                if (ar_fire_w) begin
                    state_d = RD_REQ;
                    tmr_d   = TMR_LOAD;
                    addr_d  = s_axil_araddr;
                end
            end
            RD_REQ: begin
                if (push_w) begin
                    state_d = RD_IDLE;
                end else if (!reg_rd_wait && (tmr_q != '0)) begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RD_IDLE;
            stat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stat_q  <= timeout_w;
        end
    end

    always_ff @(posedge clk) begin
        tmr_q  <= tmr_d;
        addr_q <= addr_d;
    end

    assign reg_rd_en    = (state_q == RD_REQ);
    assign reg_rd_addr  = addr_q;
    assign stat_timeout = stat_q;

    axil_reg_rd_resp_fifo #(
        .WIDTH (DATA_WIDTH + 2),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_w),
        .push_data_i (push_data_w),
        .pop_i       (s_axil_rvalid && s_axil_rready),
        .pop_data_o  (pop_data_w),
        .valid_o     (s_axil_rvalid),
        .level_o     (resp_level)
    );

    assign s_axil_rdata = pop_data_w[DATA_WIDTH+1:2];
    assign s_axil_rresp = pop_data_w[1:0];

endmodule
`default_nettype wire
